// File: rtl/mmu_seq_pkg.sv
// Shared types and constants for the 2x2 systolic matrix-unit sequencer:
// state encoding, operand-select codes and the skewed feed schedule.
package mmu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_FEED  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_K0   = 2'b01;
  localparam logic [1:0] SEL_K1   = 2'b10;

  localparam int NUM_OPERANDS = 8;
  localparam int FEED_CYCLES  = 3;

  typedef struct packed {
    logic [1:0] a0;
    logic [1:0] a1;
    logic [1:0] b0;
    logic [1:0] b1;
  } sel_t;

  localparam sel_t SEL_IDLE = '{SEL_ZERO, SEL_ZERO, SEL_ZERO, SEL_ZERO};

  // Skewed schedule: row/column 1 lags row/column 0 by one cycle.
  function automatic sel_t feed_sel(input logic [1:0] f);
    sel_t s;
    s = SEL_IDLE;
    case (f)
      2'd0:    s = '{a0: SEL_K0,   a1: SEL_ZERO, b0: SEL_K0,   b1: SEL_ZERO};
      2'd1:    s = '{a0: SEL_K1,   a1: SEL_K0,   b0: SEL_K1,   b1: SEL_K0};
      2'd2:    s = '{a0: SEL_ZERO, a1: SEL_K1,   b0: SEL_ZERO, b1: SEL_K1};
      default: s = SEL_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmu_sequencer_result_serializer.sv
// Holds the four captured accumulations and streams them out over a
// ready/valid byte port. MMU_SEQ_SAT8_EN selects one clamped byte per result.
module result_serializer #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             out_ready,
  input  logic [ACC_W-1:0] c00,
  input  logic [ACC_W-1:0] c01,
  input  logic [ACC_W-1:0] c10,
  input  logic [ACC_W-1:0] c11,
  output logic [7:0]       data_out,
  output logic             out_valid,
  output logic             done,
  output logic             last_accepted
);

`ifdef MMU_SEQ_SAT8_EN
  localparam logic [2:0] LAST_IDX = 3'd3;
  localparam logic signed [ACC_W-1:0] MAX8 = 127;
  localparam logic signed [ACC_W-1:0] MIN8 = -128;

  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
    logic [7:0] r;
    if (v > MAX8)      r = 8'h7F;
    else if (v < MIN8) r = 8'h80;
    else               r = v[7:0];
    return r;
  endfunction
`else
  localparam logic [2:0] LAST_IDX = 3'd7;
`endif

  logic [ACC_W-1:0] hold [4];
  logic [2:0]       idx;
  logic [ACC_W-1:0] cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hold[i] <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      hold[0]   <= c00;
      hold[1]   <= c01;
      hold[2]   <= c10;
      hold[3]   <= c11;
      idx       <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (idx == LAST_IDX) begin
        out_valid <= 1'b0;
        idx       <= '0;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Output byte is a pure function of the holding registers and index.
  always_comb begin
    cur      = '0;
    data_out = '0;
`ifdef MMU_SEQ_SAT8_EN
    cur      = hold[idx[1:0]];
    data_out = sat8(cur);
`else
    cur      = hold[idx[2:1]];
    data_out = idx[0] ? cur[15:8] : cur[7:0];
`endif
  end

  assign done          = out_valid && (idx == LAST_IDX);
  assign last_accepted = done && out_ready;

endmodule

// File: rtl/mmu_sequencer.sv
// Transaction sequencer for the 2x2 systolic matrix unit: load, clear, skewed
// feed, flush, then serialized results. Optional MMU_SEQ_SAT8_EN: 8-bit clamped results.
module mmu_sequencer
  import mmu_seq_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ACC_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             out_ready,
  input  logic [ACC_W-1:0] c00,
  input  logic [ACC_W-1:0] c01,
  input  logic [ACC_W-1:0] c10,
  input  logic [ACC_W-1:0] c11,
  output logic [2:0]       mem_addr,
  output logic             mem_we,
  output logic             clear,
  output logic [1:0]       a0_sel,
  output logic [1:0]       a1_sel,
  output logic [1:0]       b0_sel,
  output logic [1:0]       b1_sel,
  output logic [7:0]       data_out,
  output logic             out_valid,
  output logic             done,
  output logic             busy
);

  localparam int FLW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t         state;
  logic [2:0]     lcnt;
  logic [1:0]     fcnt;
  logic [FLW-1:0] flcnt;
  sel_t           sel;
  logic           capture;
  logic           last_accepted;

  assign capture = (state == ST_FLUSH) && (flcnt == FLW'(FLUSH_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      lcnt  <= '0;
      fcnt  <= '0;
      flcnt <= '0;
      clear <= 1'b0;
      sel   <= SEL_IDLE;
    end else begin
      clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_en) begin
            lcnt  <= lcnt + 3'd1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // lcnt wraps 7 -> 0 on the final write, ready for the next transaction.
          if (load_en) begin
            lcnt <= lcnt + 3'd1;
            if (lcnt == 3'(NUM_OPERANDS - 1)) begin
              state <= ST_CLEAR;
              clear <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          state <= ST_FEED;
          fcnt  <= '0;
          sel   <= feed_sel(2'd0);
        end
        ST_FEED: begin
          if (fcnt == 2'(FEED_CYCLES - 1)) begin
            state <= ST_FLUSH;
            flcnt <= '0;
            sel   <= SEL_IDLE;
          end else begin
            fcnt <= fcnt + 2'd1;
            sel  <= feed_sel(fcnt + 2'd1);
          end
        end
        ST_FLUSH: begin
          if (capture) state <= ST_OUT;
          else         flcnt <= flcnt + FLW'(1);
        end
        ST_OUT: begin
          if (last_accepted) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we   = load_en && ((state == ST_IDLE) || (state == ST_LOAD));
  assign mem_addr = lcnt;
  assign busy     = (state != ST_IDLE);
  assign a0_sel   = sel.a0;
  assign a1_sel   = sel.a1;
  assign b0_sel   = sel.b0;
  assign b1_sel   = sel.b1;

  result_serializer #(.ACC_W(ACC_W)) u_ser (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture       (capture),
    .out_ready     (out_ready),
    .c00           (c00),
    .c01           (c01),
    .c10           (c10),
    .c11           (c11),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .done          (done),
    .last_accepted (last_accepted)
  );

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer: schedule table, result byte tables and
// multi-cycle corner cases (load gap, ready stall, mid-feed reset, back-to-back).
module tb_mmu_sequencer;

`ifdef MMU_SEQ_SAT8_EN
  localparam int N_BYTES = 4;
`else
  localparam int N_BYTES = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic        out_ready;
  logic [15:0] c00, c01, c10, c11;
  logic [2:0]  mem_addr;
  logic        mem_we, clear;
  logic [1:0]  a0_sel, a1_sel, b0_sel, b1_sel;
  logic [7:0]  data_out;
  logic        out_valid, done, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmu_sequencer #(.FLUSH_CYCLES(2), .ACC_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .out_ready (out_ready),
    .c00       (c00),
    .c01       (c01),
    .c10       (c10),
    .c11       (c11),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .clear     (clear),
    .a0_sel    (a0_sel),
    .a1_sel    (a1_sel),
    .b0_sel    (b0_sel),
    .b1_sel    (b1_sel),
    .data_out  (data_out),
    .out_valid (out_valid),
    .done      (done),
    .busy      (busy)
  );

  typedef struct {
    logic       load_en;
    logic       clear;
    logic [1:0] a0, a1, b0, b1;
    logic       out_valid;
  } sched_t;

  sched_t      sched [6];
  logic [15:0] c_set [3][4];
  logic [7:0]  exp_bytes [3][8];

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic ld, input logic rdy);
    @(negedge clk);
    load_en   = ld;
    out_ready = rdy;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_mem_we"}, mem_we, 0);
    check_output({tag, "_mem_addr"}, mem_addr, 0);
    check_output({tag, "_clear"}, clear, 0);
    check_output({tag, "_sels"}, {a0_sel, a1_sel, b0_sel, b1_sel}, 0);
    check_output({tag, "_data_out"}, data_out, 0);
    check_output({tag, "_out_valid"}, out_valid, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_busy"}, busy, 0);
  endtask

  // One full transaction. first_byte=1 means byte 0 was already written in the
  // cycle that accepted the previous done. chain_next writes the next byte 0 there.
  task automatic run_txn(input int set, input bit gap, input int drop_byte,
                         input int first_byte, input bit chain_next);
    c00 = c_set[set][0];
    c01 = c_set[set][1];
    c10 = c_set[set][2];
    c11 = c_set[set][3];
    for (int i = first_byte; i < 8; i++) begin
      apply_stimulus(1'b1, 1'b1);
      check_output("load_mem_we", mem_we, 1);
      check_output("load_mem_addr", mem_addr, 16'(i));
      check_output("load_busy", busy, (i == 0) ? 16'd0 : 16'd1);
      if (gap && i == 3) begin
        for (int g = 0; g < 3; g++) begin
          apply_stimulus(1'b0, 1'b1);
          check_output("gap_mem_we", mem_we, 0);
          check_output("gap_mem_addr", mem_addr, 4);
          check_output("gap_busy", busy, 1);
        end
      end
    end
    for (int s = 0; s < 6; s++) begin
      apply_stimulus(sched[s].load_en, 1'b1);
      check_output("sched_clear", clear, sched[s].clear);
      check_output("sched_a0", a0_sel, sched[s].a0);
      check_output("sched_a1", a1_sel, sched[s].a1);
      check_output("sched_b0", b0_sel, sched[s].b0);
      check_output("sched_b1", b1_sel, sched[s].b1);
      check_output("sched_out_valid", out_valid, sched[s].out_valid);
      check_output("sched_mem_we", mem_we, 0);
      check_output("sched_busy", busy, 1);
    end
    for (int k = 0; k < N_BYTES; k++) begin
      if (k == drop_byte) begin
        for (int d = 0; d < 5; d++) begin
          apply_stimulus(1'b0, 1'b0);
          check_output("stall_out_valid", out_valid, 1);
          check_output("stall_data_out", data_out, exp_bytes[set][k]);
          check_output("stall_done", done, (k == N_BYTES - 1) ? 16'd1 : 16'd0);
        end
      end
      apply_stimulus(1'b0, 1'b1);
      if (k == 0) begin
        c00 = 16'hDEAD; c01 = 16'hBEEF; c10 = 16'h5A5A; c11 = 16'hA5A5;
      end
      check_output("out_valid", out_valid, 1);
      check_output("out_data", data_out, exp_bytes[set][k]);
      check_output("out_done", done, (k == N_BYTES - 1) ? 16'd1 : 16'd0);
      check_output("out_busy", busy, 1);
      check_output("out_clear", clear, 0);
    end
    apply_stimulus(chain_next, 1'b1);
    check_output("post_busy", busy, 0);
    check_output("post_out_valid", out_valid, 0);
    check_output("post_done", done, 0);
    check_output("post_mem_we", mem_we, chain_next);
    check_output("post_mem_addr", mem_addr, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sched[0] = '{1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    sched[1] = '{1'b1, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0, 1'b0};
    sched[2] = '{1'b1, 1'b0, 2'd2, 2'd1, 2'd2, 2'd1, 1'b0};
    sched[3] = '{1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0};
    sched[4] = '{1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    sched[5] = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};

    c_set[0] = '{16'd19, 16'd22, 16'd43, 16'd50};
    c_set[1] = '{16'd300, 16'hFF38, 16'd5, 16'hFFFF};
    c_set[2] = '{16'h1234, 16'hFFFE, 16'h8000, 16'h7FFF};
`ifdef MMU_SEQ_SAT8_EN
    exp_bytes[0] = '{8'h13, 8'h16, 8'h2B, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_bytes[1] = '{8'h7F, 8'h80, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_bytes[2] = '{8'h7F, 8'hFE, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    exp_bytes[0] = '{8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32, 8'h00};
    exp_bytes[1] = '{8'h2C, 8'h01, 8'h38, 8'hFF, 8'h05, 8'h00, 8'hFF, 8'hFF};
    exp_bytes[2] = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h7F};
`endif

    rst_n = 1'b0; load_en = 1'b0; out_ready = 1'b0;
    c00 = '0; c01 = '0; c10 = '0; c11 = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    run_txn(0, 1'b0, -1, 0, 1'b0);
    run_txn(1, 1'b1, -1, 0, 1'b0);
    run_txn(0, 1'b0, 3, 0, 1'b0);
    run_txn(2, 1'b0, -1, 0, 1'b1);
    run_txn(1, 1'b0, -1, 1, 1'b0);

    // Abort mid-FEED: load all 8 bytes, run into the second feed cycle, reset.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    check_output("abort_clear", clear, 1);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    check_output("abort_pre_a1", a1_sel, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    apply_stimulus(1'b0, 1'b1);
    check_all_zero("abort_hold");
    rst_n = 1'b1;
    run_txn(2, 1'b0, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
